cpsum_drain: RTL
================

# cpsum_drain

Drain stage on the consumer side of the channel-partial-sum accumulator (`c_psum`). When `c_psum` pulses `o_finish`, this block captures the full `o_cpsum` vector (mac_number×pe_number lanes of 22-bit signed sums) into a local buffer. It then requantizes each lane to an unsigned 4-bit activation using rounding right shift and clamping. The result streams out one MAC row per beat over a valid/ready handshake toward the activation write-back path.

## Interface
- `mac_number`, 14, MAC rows per tile; equals the beats per drain.
- `pe_number`, 64, lanes per row.
- `psum_width`, 22, signed width of each input partial sum.
- `out_width`, 4, unsigned width of each output activation.
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `i_cpsum`  in  psum_width·mac_number·pe_number  packed sums; lane L = m·pe_number+p at bits [psum_width·L +: psum_width].
- `i_finish`  in  1  one-cycle pulse; `i_cpsum` valid in the same cycle.
- `shift`  in  5  right-shift amount; sampled at capture; values >21 are treated as 21.
- `o_data`  out  out_width·pe_number  current row; lane p at [out_width·p +: out_width].
- `o_valid`  out  1  beat available.
- `i_ready`  in  1  downstream accepts the beat.
- `o_row`  out  $clog2(mac_number)  row index m of the current beat.
- `o_last`  out  1  high with the beat where m = mac_number−1.
- `o_busy`  out  1  high whenever the state is not IDLE.
- `o_drop`  out  1  one-cycle pulse when an `i_finish` is rejected.

## Operation
- States: IDLE, LOAD, SEND.
- IDLE:
  - If `i_finish` is high, capture `i_cpsum` into the buffer and `shift` into `shift_q`, then go to LOAD.
- LOAD:
  - Load the output register with row 0 (requantized). Set `o_valid` = 1, `o_row` = 0, then go to SEND.
- SEND:
  - On handshake (`o_valid && i_ready`) with m < mac_number−1: load row m+1 at the same edge. `o_valid` stays high, so throughput is one beat per cycle.
  - On handshake of the last beat: clear `o_valid` and go to IDLE. Exception: if `i_finish` is high in that same cycle, capture the new vector and go to LOAD (back-to-back tiles).
  - Without a handshake, `o_data`, `o_row` and `o_last` hold stable. This includes when `i_ready` drops mid-drain.
- Rejection: `i_finish` in LOAD, or in SEND other than the last-handshake cycle, is ignored and pulses `o_drop` on the next cycle. The buffer is not disturbed.
- Requantization of a lane x (signed psum_width), with s = `shift_q`:
  - Add the rounding term 2^(s−1) when s > 0, otherwise 0. The sum is 23 bits signed, so it cannot overflow.
  - Arithmetic right shift by s.
  - Clamp to [0, 2^out_width−1]. Negative values give 0; values ≥16 give 15.
- A single `shift_q` value applies to the whole tile.

## Timing
- Reset values:
  - `o_valid`, `o_last`, `o_busy`, `o_drop` = 0.
  - `o_data` = 0, `o_row` = 0, state = IDLE, buffer = 0.
- Reset acts immediately, including mid-drain. Any remaining beats are discarded, never emitted.
- Latency: `i_finish` sampled at edge E0 → LOAD during the next cycle → first beat valid after edge E1 (2 edges).
- Minimum drain with `i_ready` held high: 1 LOAD cycle + mac_number beat cycles.
- Back-to-back tiles: one LOAD bubble between the last beat of tile k and row 0 of tile k+1.
- `o_drop` pulses for exactly one cycle per rejected `i_finish`.

## Structure
- Shared package:
  - Default localparams: MAC_NUMBER, PE_NUMBER, PSUM_W = 22, ACT_W = 4.
  - State enum for IDLE/LOAD/SEND.
  - Constant SHIFT_MAX = 21.
- Sub-module `psum_requant`: combinational, one lane (round, shift, clamp). It is instantiated pe_number times with a generate loop, fed through a row mux selected by the next row index.
- Top level holds the buffer, FSM, row counter and output register.

## Test plan
- Single tile, shift = 0, `i_ready` = 1, lane values −3, 0, 7, 15, 16, 2097151 → outputs 0, 0, 7, 15, 15, 15; 14 beats, `o_row` 0..13, `o_last` only on beat 13, first `o_valid` two edges after `i_finish`.
- shift = 2, lanes 5, 6, −2, 61 → (5+2)>>2 = 1, (6+2)>>2 = 2, 0, (61+2)>>2 = 15; shift = 31 on lane 2^21−1 → treated as 21 → 1.
- Backpressure: `i_ready` toggles 1, 0, 0, 1, … → `o_data` and `o_row` stay stable while stalled; all 14 rows are delivered exactly once, in order, with no duplicates.
- Back-to-back: second `i_finish` in the cycle of the row-13 handshake → captured, no `o_drop`, one bubble, then row 0 of the new tile. A third `i_finish` at row 5 → `o_drop` pulses once and the current tile completes unchanged.
- Reset mid-drain at row 7: `rst_n` low → `o_valid` = 0 immediately and all outputs return to reset values. After release, a new `i_finish` drains rows 0..13 normally.

Source files
------------

// File: rtl/cpsum_drain_pkg.sv
// Shared constants and state encoding for the c_psum drain stage.
package cpsum_drain_pkg;
  localparam int MAC_NUMBER = 14;
  localparam int PE_NUMBER  = 64;
  localparam int PSUM_W     = 22;
  localparam int ACT_W      = 4;
  localparam int SHIFT_W    = 5;
  localparam int SHIFT_MAX  = 21;
  localparam int ROW_W      = $clog2(MAC_NUMBER);
  localparam int ROW_BITS   = PE_NUMBER * PSUM_W;
  localparam int BUF_BITS   = MAC_NUMBER * ROW_BITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_t;
endpackage

// File: rtl/cpsum_drain_requant.sv
// One-lane requantizer: round-half-up right shift, then clamp to the unsigned activation range.
module psum_requant
  import cpsum_drain_pkg::*;
(
  input  logic signed [PSUM_W-1:0]  psum,
  input  logic        [SHIFT_W-1:0] shift,
  output logic        [ACT_W-1:0]   act
);
  localparam logic signed [PSUM_W:0] ACT_MAX = (PSUM_W+1)'((1 << ACT_W) - 1);

  logic signed [PSUM_W:0] round_term;
  logic signed [PSUM_W:0] rounded;
  logic signed [PSUM_W:0] shifted;

  always_comb begin
    round_term = '0;
    if (shift != '0) round_term = (PSUM_W+1)'(1) << (shift - SHIFT_W'(1));
    rounded = {psum[PSUM_W-1], psum} + round_term;
    shifted = rounded >>> shift;
    if (shifted[PSUM_W])          act = '0;
    else if (shifted > ACT_MAX)   act = '1;
    else                          act = shifted[ACT_W-1:0];
  end
endmodule

// File: rtl/cpsum_drain.sv
// Captures a full partial-sum tile on i_finish and streams requantized rows over valid/ready.
// state | meaning
// IDLE  | waiting for i_finish
// LOAD  | tile captured, row 0 being loaded into the output register
// SEND  | beats presented; advance one row per handshake
module cpsum_drain
  import cpsum_drain_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [BUF_BITS-1:0]           i_cpsum,
  input  logic                          i_finish,
  input  logic [SHIFT_W-1:0]            shift,
  output logic [ACT_W*PE_NUMBER-1:0]    o_data,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [ROW_W-1:0]              o_row,
  output logic                          o_last,
  output logic                          o_busy,
  output logic                          o_drop
);
  state_t state_q, state_d;
  logic [BUF_BITS-1:0]          buf_q;
  logic [SHIFT_W-1:0]           shift_q;
  logic [ROW_W-1:0]             row_q, next_row;
  logic [ACT_W*PE_NUMBER-1:0]   data_q, act_row;
  logic [ROW_BITS-1:0]          row_slice;
  logic valid_q, valid_d, last_q, drop_q, drop_d;
  logic capture, load, hs;

  assign hs = valid_q & i_ready;

  always_comb begin
    state_d  = state_q;
    capture  = 1'b0;
    load     = 1'b0;
    valid_d  = valid_q;
    drop_d   = 1'b0;
    next_row = last_q ? '0 : row_q + ROW_W'(1);
    case (state_q)
      IDLE: begin
        if (i_finish) begin
          capture = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        load     = 1'b1;
        next_row = '0;
        valid_d  = 1'b1;
        drop_d   = i_finish;
        state_d  = SEND;
      end
      SEND: begin
        drop_d = i_finish & ~(hs & last_q);
        if (hs) begin
          if (last_q) begin
            valid_d = 1'b0;
            if (i_finish) begin
              capture = 1'b1;
              state_d = LOAD;
            end else begin
              state_d = IDLE;
            end
          end else begin
            load = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign row_slice = buf_q[int'(next_row)*ROW_BITS +: ROW_BITS];

  for (genvar p = 0; p < PE_NUMBER; p++) begin : g_lane
    psum_requant u_requant (
      .psum  (row_slice[p*PSUM_W +: PSUM_W]),
      .shift (shift_q),
      .act   (act_row[p*ACT_W +: ACT_W])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      buf_q   <= '0;
      shift_q <= '0;
      row_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
      if (capture) begin
        buf_q   <= i_cpsum;
        shift_q <= (shift > SHIFT_W'(SHIFT_MAX)) ? SHIFT_W'(SHIFT_MAX) : shift;
      end
      if (load) begin
        data_q <= act_row;
        row_q  <= next_row;
        last_q <= (next_row == ROW_W'(MAC_NUMBER - 1));
      end else if (!valid_d) begin
        last_q <= 1'b0;
      end
    end
  end

  assign o_data  = data_q;
  assign o_valid = valid_q;
  assign o_row   = row_q;
  assign o_last  = last_q;
  assign o_busy  = (state_q != IDLE);
  assign o_drop  = drop_q;
endmodule
